// File: rtl/io_pulse_pkg.sv
// Shared definitions for the IO controller pulse train generator:
// phase encoding and default counter widths.
package io_pulse_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_NUM_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// phase_timer: loadable down-counter that measures one phase of the pulse
// train. Load has priority over decrement; the count holds at zero and
// zero is flagged combinationally.
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Counter register: reload on phase entry, otherwise count down per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: drives a train of active-high pulses on pulse_out with
// programmable high/low widths counted in enable ticks.
// Optional build macro PULSE_CONTINUOUS_EN: num_pulses=0 starts an endless
// train that only stop can end.
//
// Handshake: busy is high for the whole train; done is a one-clk pulse on
// the cycle after the train ends (completed or aborted). A new start is
// accepted whenever the block is IDLE, including the cycle where done=1.
module pulse_train_gen
  import io_pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  // Phase timer loads len-1; a zero length behaves like one tick.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    len_m1 = (len == '0) ? '0 : len - {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state, state_next;
  logic [CNT_W-1:0] high_lat, high_next;
  logic [CNT_W-1:0] low_lat, low_next;
  logic [NUM_W-1:0] num_lat, num_next;
  logic [NUM_W-1:0] cnt, cnt_next, cnt_inc;
  logic             pulse_next, busy_next, done_next;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             num_ok, accept, last_pulse, endless;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign cnt_inc = cnt + {{(NUM_W-1){1'b0}}, 1'b1};

`ifdef PULSE_CONTINUOUS_EN
  assign num_ok  = 1'b1;
  assign endless = (num_lat == '0);
`else
  assign num_ok  = (num_pulses != '0);
  assign endless = 1'b0;
`endif

  assign accept     = enable && start && !stop && num_ok;
  assign last_pulse = !endless && (cnt_inc == num_lat);

  // State, latched parameters, pulse counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      high_lat  <= '0;
      low_lat   <= '0;
      num_lat   <= '0;
      cnt       <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      high_lat  <= high_next;
      low_lat   <= low_next;
      num_lat   <= num_next;
      cnt       <= cnt_next;
      pulse_out <= pulse_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Next-state and output decode; everything holds unless enable=1,
  // except done which always clears after one cycle.
  always_comb begin
    state_next = state;
    high_next  = high_lat;
    low_next   = low_lat;
    num_next   = num_lat;
    cnt_next   = cnt;
    pulse_next = pulse_out;
    busy_next  = busy;
    done_next  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          high_next  = high_len;
          low_next   = low_len;
          num_next   = num_pulses;
          cnt_next   = '0;
          state_next = HIGH;
          pulse_next = 1'b1;
          busy_next  = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = len_m1(high_len);
        end
      end

      HIGH: begin
        if (enable) begin
          if (stop) begin
            state_next = IDLE;
            pulse_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else if (tmr_zero) begin
            state_next = LOW;
            pulse_next = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = len_m1(low_lat);
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end

      LOW: begin
        if (enable) begin
          if (stop) begin
            state_next = IDLE;
            pulse_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else if (tmr_zero) begin
            // Endless trains never advance the count so it cannot wrap.
            if (!endless) cnt_next = cnt_inc;
            if (last_pulse) begin
              state_next = IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              state_next = HIGH;
              pulse_next = 1'b1;
              tmr_load   = 1'b1;
              tmr_val    = len_m1(high_lat);
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        pulse_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen: directed scenarios plus random traffic,
// checked against a tick-queue reference model of the output waveform.
module tb_pulse_train_gen;

  localparam int CNT_W = 16;
  localparam int NUM_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable, start, stop;
  logic [CNT_W-1:0] high_len, low_len;
  logic [NUM_W-1:0] num_pulses;
  logic             pulse_out, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining output levels, one entry per enabled tick.
  bit   tq[$];
  bit   cont_m = 1'b0;
  logic exp_pulse = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

  logic [10:0] p_hist, b_hist, d_hist;

  pulse_train_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clk edge with the given inputs.
  task automatic model_step(input bit en, input bit st, input bit sp,
                            input int h, input int l, input int n);
    bit b;
    int hh, ll, reps;
    exp_done = 1'b0;
    if (en) begin
      if (tq.size() != 0) begin
        if (sp) begin
          tq.delete();
          cont_m   = 1'b0;
          exp_done = 1'b1;
        end else begin
          b = tq.pop_front();
          if (cont_m) tq.push_back(b);
          if (tq.size() == 0) exp_done = 1'b1;
        end
      end else begin
`ifdef PULSE_CONTINUOUS_EN
        if (st && !sp) begin
`else
        if (st && !sp && n != 0) begin
`endif
          hh     = (h == 0) ? 1 : h;
          ll     = (l == 0) ? 1 : l;
          cont_m = (n == 0);
          reps   = (n == 0) ? 1 : n;
          for (int k = 0; k < reps; k++) begin
            for (int j = 0; j < hh; j++) tq.push_back(1'b1);
            for (int j = 0; j < ll; j++) tq.push_back(1'b0);
          end
        end
      end
    end
    exp_pulse = (tq.size() != 0) ? tq[0] : 1'b0;
    exp_busy  = (tq.size() != 0);
  endtask

  // Drive one cycle from a negedge, step the model, check at the next negedge.
  task automatic drive_cycle(input bit en, input bit st, input bit sp,
                             input int h, input int l, input int n);
    enable     = en;
    start      = st;
    stop       = sp;
    high_len   = CNT_W'(h);
    low_len    = CNT_W'(l);
    num_pulses = NUM_W'(n);
    model_step(en, st, sp, h, l, n);
    @(posedge clk);
    @(negedge clk);
    check_eq("pulse_out", {31'd0, pulse_out}, {31'd0, exp_pulse});
    check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
    check_eq("done", {31'd0, done}, {31'd0, exp_done});
    p_hist = {p_hist[9:0], pulse_out};
    b_hist = {b_hist[9:0], busy};
    d_hist = {d_hist[9:0], done};
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; start = 1'b0; stop = 1'b0;
    high_len = '0; low_len = '0; num_pulses = '0;
    p_hist = '0; b_hist = '0; d_hist = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_pulse", {31'd0, pulse_out}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Completed train: h=3 l=2 n=2, fixed waveform over cycles 1..11.
    drive_cycle(1'b1, 1'b1, 1'b0, 3, 2, 2);
    idle_cycles(10);
    check_eq("train_pulse_wave", {21'd0, p_hist}, {21'd0, 11'b11100111000});
    check_eq("train_busy_wave", {21'd0, b_hist}, {21'd0, 11'b11111111110});
    check_eq("train_done_wave", {21'd0, d_hist}, {21'd0, 11'b00000000001});
    idle_cycles(2);

    // Zero lengths: one tick high, one tick low, three pulses.
    drive_cycle(1'b1, 1'b1, 1'b0, 0, 0, 3);
    idle_cycles(8);

    // Abort on cycle 4 of a long train.
    drive_cycle(1'b1, 1'b1, 1'b0, 10, 3, 5);
    idle_cycles(3);
    drive_cycle(1'b1, 1'b0, 1'b1, 0, 0, 0);
    idle_cycles(6);

    // Enable every fourth clk: h=2 l=1 n=1.
    drive_cycle(1'b1, 1'b1, 1'b0, 2, 1, 1);
    for (int i = 1; i < 18; i++) drive_cycle((i % 4) == 0, 1'b0, 1'b0, 0, 0, 0);
    idle_cycles(2);

    // Start held and parameters changed mid-train.
    drive_cycle(1'b1, 1'b1, 1'b0, 2, 1, 3);
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b1, 1'b1, 1'b0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 5));
    idle_cycles(3);

    // start together with stop in IDLE does nothing.
    drive_cycle(1'b1, 1'b1, 1'b1, 2, 2, 2);
    idle_cycles(2);

    // num_pulses=0: ignored by default, endless train with the macro.
    drive_cycle(1'b1, 1'b1, 1'b0, 2, 2, 0);
    idle_cycles(20);
    drive_cycle(1'b1, 1'b0, 1'b1, 0, 0, 0);
    idle_cycles(3);

    // Asynchronous reset during a high phase.
    drive_cycle(1'b1, 1'b1, 1'b0, 8, 2, 2);
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_pulse", {31'd0, pulse_out}, 32'd0);
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    tq.delete();
    cont_m = 1'b0;
    exp_pulse = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("in_rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    drive_cycle(1'b1, 1'b1, 1'b0, 1, 1, 1);
    idle_cycles(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 30) == 0, $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 3));
    drive_cycle(1'b1, 1'b0, 1'b1, 0, 0, 0);
    idle_cycles(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
